// File: rtl/charbuf_writer_pkg.sv
// Shared definitions for the character-buffer write engine: geometry defaults,
// control codes, FSM/cursor encodings and buffer address/data packing.
package charbuf_writer_pkg;

  localparam int COLS_DEF = 60;
  localparam int ROWS_DEF = 17;

  localparam int XW = 6;           // physical columns 0..63
  localparam int YW = 5;           // physical rows 0..31
  localparam int AW = XW + YW;     // buffer address width
  localparam int DW = 16;          // buffer data width {attr, char}
  localparam int CW = AW + 1;      // clear counter, MSB flags "done"

  localparam logic [7:0] CHAR_BS    = 8'h08;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_FF    = 8'h0C;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  typedef enum logic [1:0] {
    ST_CLR_ALL  = 2'd0,
    ST_IDLE     = 2'd1,
    ST_CLR_LINE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    CUR_HOLD = 3'd0,
    CUR_HOME = 3'd1,
    CUR_CR   = 3'd2,
    CUR_LF   = 3'd3,
    CUR_BS   = 3'd4,
    CUR_ADV  = 3'd5,
    CUR_WRAP = 3'd6
  } cur_cmd_t;

  function automatic logic [AW-1:0] pack_addr(input logic [YW-1:0] y,
                                              input logic [XW-1:0] x);
    return {y, x};
  endfunction

  function automatic logic [DW-1:0] pack_data(input logic [7:0] attr,
                                              input logic [7:0] ch);
    return {attr, ch};
  endfunction

endpackage

// File: rtl/charbuf_writer_text_cursor.sv
// Cursor registers for the visible text grid: column advance, backspace,
// carriage return and row stepping with wrap from the last row to the top.
module charbuf_writer_text_cursor
  import charbuf_writer_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  cur_cmd_t      i_cmd,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic [YW-1:0] o_y_next,
  output logic          o_x_last,
  output logic          o_x_zero
);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [YW-1:0] y_next;

  // No scrolling: the row after the last visible one is the top row.
  always_comb begin
    y_next = (y_q == YW'(ROWS - 1)) ? '0 : y_q + YW'(1);
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    case (i_cmd)
      CUR_HOME: begin
        x_d = '0;
        y_d = '0;
      end
      CUR_CR:   x_d = '0;
      CUR_LF:   y_d = y_next;
      CUR_BS: begin
        if (x_q != '0) x_d = x_q - XW'(1);
      end
      CUR_ADV:  x_d = x_q + XW'(1);
      CUR_WRAP: begin
        x_d = '0;
        y_d = y_next;
      end
      default: begin
        x_d = x_q;
        y_d = y_q;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign o_x      = x_q;
  assign o_y      = y_q;
  assign o_y_next = y_next;
  assign o_x_last = (x_q == XW'(COLS - 1));
  assign o_x_zero = (x_q == '0);

endmodule

// File: rtl/charbuf_writer.sv
// Write-side engine for the text-mode character buffer: turns a stream of
// {attr, char} into port-A writes, handling CR/LF/BS/FF and screen/line clears.
module charbuf_writer
  import charbuf_writer_pkg::*;
#(
  parameter int         COLS     = COLS_DEF,
  parameter int         ROWS     = ROWS_DEF,
  parameter logic [7:0] DEF_ATTR = 8'h07
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [7:0]   i_char,
  input  logic [7:0]   i_attr,
  output logic [10:0]  o_ada,
  output logic [15:0]  o_din,
  output logic         o_cea,
  output logic [5:0]   o_cur_x,
  output logic [4:0]   o_cur_y
);

  localparam logic [DW-1:0] BLANK = {DEF_ATTR, CHAR_SPACE};

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           cea_q, cea_d;
  logic [AW-1:0]  ada_q, ada_d;
  logic [DW-1:0]  din_q, din_d;

  cur_cmd_t       cur_cmd;
  logic [XW-1:0]  cur_x;
  logic [YW-1:0]  cur_y;
  logic [YW-1:0]  cur_y_next;
  logic           cur_x_last;
  logic           cur_x_zero;

  charbuf_writer_text_cursor #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_cursor (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_cmd    (cur_cmd),
    .o_x      (cur_x),
    .o_y      (cur_y),
    .o_y_next (cur_y_next),
    .o_x_last (cur_x_last),
    .o_x_zero (cur_x_zero)
  );

  // Handshake: a character transfers on a rising edge where i_valid and o_ready
  // are both high; the source holds i_char/i_attr stable until that edge.
  assign o_ready = (state_q == ST_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cea_d   = 1'b0;
    ada_d   = ada_q;
    din_d   = din_q;
    cur_cmd = CUR_HOLD;
    case (state_q)
      ST_CLR_ALL: begin
        // Counter MSB set means all 2048 cells have been blanked.
        if (cnt_q[AW]) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          cur_cmd = CUR_HOME;
        end else begin
          cea_d = 1'b1;
          ada_d = cnt_q[AW-1:0];
          din_d = BLANK;
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_CLR_LINE: begin
        if (cnt_q[XW]) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cea_d = 1'b1;
          ada_d = pack_addr(cur_y, cnt_q[XW-1:0]);
          din_d = BLANK;
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_IDLE: begin
        if (i_valid) begin
          case (i_char)
            CHAR_CR: cur_cmd = CUR_CR;
            CHAR_LF: begin
              // Column 0 of the new row is blanked on the accept edge itself;
              // the line clear then continues from column 1.
              cur_cmd = CUR_LF;
              cea_d   = 1'b1;
              ada_d   = pack_addr(cur_y_next, '0);
              din_d   = BLANK;
              cnt_d   = CW'(1);
              state_d = ST_CLR_LINE;
            end
            CHAR_BS: begin
              if (!cur_x_zero) begin
                cur_cmd = CUR_BS;
                cea_d   = 1'b1;
                ada_d   = pack_addr(cur_y, cur_x - XW'(1));
                din_d   = BLANK;
              end
            end
            CHAR_FF: begin
              cur_cmd = CUR_HOME;
              cnt_d   = '0;
              state_d = ST_CLR_ALL;
            end
            default: begin
              cea_d = 1'b1;
              ada_d = pack_addr(cur_y, cur_x);
              din_d = pack_data(i_attr, i_char);
              if (cur_x_last) begin
                cur_cmd = CUR_WRAP;
                cnt_d   = '0;
                state_d = ST_CLR_LINE;
              end else begin
                cur_cmd = CUR_ADV;
              end
            end
          endcase
        end
      end
      default: begin
        state_d = ST_CLR_ALL;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_CLR_ALL;
      cnt_q   <= '0;
      cea_q   <= 1'b0;
      ada_q   <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cea_q   <= cea_d;
      ada_q   <= ada_d;
      din_q   <= din_d;
    end
  end

  assign o_cea   = cea_q;
  assign o_ada   = ada_q;
  assign o_din   = din_q;
  assign o_cur_x = cur_x;
  assign o_cur_y = cur_y;

endmodule

// File: tb/tb_charbuf_writer.sv
// Bench for charbuf_writer: randomized and directed character streams checked
// against a grid-level model of writes, cursor position and busy time.
module tb_charbuf_writer;

  localparam int         COLS     = 60;
  localparam int         ROWS     = 17;
  localparam logic [7:0] DEF_ATTR = 8'h07;
  localparam logic [15:0] BLANK_W = 16'h0720;
  localparam int         BOUND    = 5000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [7:0]  i_char = 8'h00;
  logic [7:0]  i_attr = 8'h00;
  logic        o_ready;
  logic [10:0] o_ada;
  logic [15:0] o_din;
  logic        o_cea;
  logic [5:0]  o_cur_x;
  logic [4:0]  o_cur_y;

  logic [26:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int cx = 0;
  int cy = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  charbuf_writer #(
    .COLS     (COLS),
    .ROWS     (ROWS),
    .DEF_ATTR (DEF_ATTR)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_char  (i_char),
    .i_attr  (i_attr),
    .o_ada   (o_ada),
    .o_din   (o_din),
    .o_cea   (o_cea),
    .o_cur_x (o_cur_x),
    .o_cur_y (o_cur_y)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic push_wr(input int x, input int y, input logic [15:0] d);
    logic [10:0] a;
    a = 11'(y * 64 + x);
    exp_q.push_back({a, d});
  endtask

  task automatic push_line(input int y);
    for (int x = 0; x < 64; x++) push_wr(x, y, BLANK_W);
  endtask

  task automatic push_all();
    for (int a = 0; a < 2048; a++) exp_q.push_back({11'(a), BLANK_W});
  endtask

  // Applies one accepted character; returns how many cycles o_ready stays low after it.
  task automatic model_accept(input logic [7:0] c, input logic [7:0] a, output int busy);
    busy = 0;
    case (c)
      8'h0D: cx = 0;
      8'h0A: begin
        cy = (cy + 1) % ROWS;
        push_line(cy);
        busy = 64;
      end
      8'h08: begin
        if (cx > 0) begin
          cx = cx - 1;
          push_wr(cx, cy, BLANK_W);
        end
      end
      8'h0C: begin
        push_all();
        cx = 0;
        cy = 0;
        busy = 2049;
      end
      default: begin
        push_wr(cx, cy, {a, c});
        if (cx < COLS - 1) begin
          cx = cx + 1;
        end else begin
          cx = 0;
          cy = (cy + 1) % ROWS;
          push_line(cy);
          busy = 65;
        end
      end
    endcase
  endtask

  // ---------------- scoreboard on buffer writes ----------------
  always @(negedge clk) begin
    if (o_cea === 1'b1) begin
      if (exp_q.size() == 0) check("wr_unexpected", 32'(o_cea), 32'd0);
      else check("wr", 32'({o_ada, o_din}), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic wait_ready(input string tag, input int exp_low);
    int n;
    n = 0;
    while (o_ready !== 1'b1 && n < BOUND) begin
      n++;
      @(negedge clk);
    end
    check(tag, 32'(n), 32'(exp_low));
  endtask

  task automatic check_cursor(input string tag, input int x, input int y);
    check({tag, "_x"}, 32'(o_cur_x), 32'(x));
    check({tag, "_y"}, 32'(o_cur_y), 32'(y));
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] a, input string tag);
    int busy;
    int n;
    n = 0;
    i_valid = 1'b1;
    i_char  = c;
    i_attr  = a;
    while (o_ready !== 1'b1 && n < BOUND) begin
      n++;
      @(negedge clk);
    end
    if (o_ready !== 1'b1) begin
      check({tag, "_accept"}, 32'(o_ready), 32'd1);
      i_valid = 1'b0;
      return;
    end
    model_accept(c, a, busy);
    @(negedge clk);
    i_valid = 1'b0;
    check_cursor(tag, cx, cy);
    wait_ready({tag, "_busy"}, busy);
  endtask

  task automatic drain(input string tag);
    i_valid = 1'b0;
    repeat (2) @(negedge clk);
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cea"}, 32'(o_cea), 32'd0);
    check({tag, "_ada"}, 32'(o_ada), 32'd0);
    check({tag, "_din"}, 32'(o_din), 32'd0);
    check({tag, "_ready"}, 32'(o_ready), 32'd0);
    check_cursor(tag, 0, 0);
  endtask

  task automatic release_reset(input string tag);
    rst_n = 1'b1;
    push_all();
    cx = 0;
    cy = 0;
    wait_ready({tag, "_clear"}, 2049);
    check_cursor({tag, "_home"}, 0, 0);
    drain({tag, "_drain"});
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    int ff_left;
    int r;
    logic [7:0] c;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst0");
    release_reset("init");

    // Back-to-back "AB" with valid held high
    send(8'h41, 8'h1E, "ab_a");
    send(8'h42, 8'h1E, "ab_b");
    check_cursor("ab_end", 2, 0);
    drain("ab_drain");

    // Fill row 0 to force a wrap and line clear of row 1
    send(8'h0C, 8'h00, "ff1");
    for (int i = 0; i < COLS; i++) begin
      send(8'($urandom_range(8'h21, 8'h7E)), 8'($urandom_range(0, 255)), "row0");
    end
    check_cursor("wrap_end", 0, 1);
    drain("wrap_drain");

    // LF on the last row wraps to row 0; CR returns to column 0
    send(8'h0C, 8'h00, "ff2");
    for (int i = 0; i < ROWS - 1; i++) send(8'h0A, 8'h00, "lf_down");
    for (int i = 0; i < 5; i++) send(8'h61, 8'h2A, "pad5");
    check_cursor("at_5_16", 5, 16);
    send(8'h0A, 8'h00, "lf_wrap");
    check_cursor("lf_wrap_end", 5, 0);
    send(8'h0D, 8'h00, "cr");
    check_cursor("cr_end", 0, 0);
    drain("cr_drain");

    // Backspace mid-line and at column 0
    send(8'h0A, 8'h00, "lf1");
    send(8'h0A, 8'h00, "lf2");
    for (int i = 0; i < 3; i++) send(8'h78, 8'h31, "pad3");
    check_cursor("at_3_2", 3, 2);
    send(8'h08, 8'h00, "bs_mid");
    check_cursor("bs_mid_end", 2, 2);
    send(8'h0D, 8'h00, "cr2");
    send(8'h08, 8'h00, "bs_zero");
    check_cursor("bs_zero_end", 0, 2);
    drain("bs_drain");

    // Random stream with idle gaps
    ff_left = 2;
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 6) c = 8'h0A;
      else if (r < 11) c = 8'h0D;
      else if (r < 17) c = 8'h08;
      else if (r == 17 && ff_left > 0) begin
        c = 8'h0C;
        ff_left--;
      end else c = 8'($urandom_range(0, 255));
      send(c, 8'($urandom_range(0, 255)), "rnd");
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain("rnd_drain");

    // Reset in the middle of a line clear, with a character offered
    i_valid = 1'b1;
    i_char  = 8'h0A;
    i_attr  = 8'h00;
    begin
      int busy;
      model_accept(8'h0A, 8'h00, busy);
    end
    @(negedge clk);
    i_valid = 1'b0;
    repeat (19) @(negedge clk);
    i_valid = 1'b1;
    i_char  = 8'h5A;
    i_attr  = 8'h4F;
    rst_n   = 1'b0;
    #1;
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      check("mid_rst_ready", 32'(o_ready), 32'd0);
    end
    check_reset_outputs("mid_rst");
    i_valid = 1'b0;
    release_reset("mid_rst");
    send(8'h51, 8'h70, "post_rst");
    drain("final_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
